// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM port arbiter shared by instruction fetch and data access
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   rdy               global run enable; low freezes every register and masks ram_wr
//   jump_mistake      aborts an in-flight instruction fetch
//   if_req/if_addr    fetch request (always 4 bytes) -> if_done pulse + if_data
//   mem_req/mem_we/mem_size/mem_addr/mem_wdata
//                     data request (1/2/4 bytes)    -> mem_done pulse + mem_rdata
//   ram_din           byte returned by the RAM one cycle after its address
//   ram_a/ram_dout/ram_wr
//                     byte-wide RAM address, write data and write strobe
// Optional feature macro: IO_FULL_WAIT_EN adds input io_buffer_full and holds
// off stores to the I/O window (addr[17:16] == 2'b11) while the buffer is full
// and for one cycle after each completed I/O store.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
`ifdef IO_FULL_WAIT_EN
    input  logic        io_buffer_full,
`endif
    input  logic        jump_mistake,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_wr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_if_q, owner_if_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] ram_a_q, ram_a_d;
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic        ram_wr_q, ram_wr_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        arb_free;
    logic        mem_ok;
    logic        grant_mem;
    logic        grant_if;
    logic        flush;
    logic        last_rd;
    logic        last_wr;
    logic [2:0]  cnt_nx;
    logic [2:0]  mem_len;

`ifdef IO_FULL_WAIT_EN
    logic        io_wr_q, io_wr_d;
    logic        io_last_q, io_last_d;
    logic        io_gap_q, io_gap_d;
    logic        mem_is_io_wr;

    assign mem_is_io_wr = mem_we && (mem_addr[17:16] == 2'b11);
    // io_gap_q covers the cycle after the done cycle of an I/O store, while the
    // buffer's full flag has not yet caught up with that store.
    assign mem_ok       = mem_req && !(mem_is_io_wr && (io_buffer_full || io_gap_q));
`else
    assign mem_ok       = mem_req;
`endif

    // A done pulse makes its cycle dead for arbitration.
    assign arb_free  = (state_q == ST_IDLE) && !if_done_q && !mem_done_q;
    assign grant_mem = arb_free && mem_ok;
    assign grant_if  = arb_free && !grant_mem && if_req && !jump_mistake;
    assign flush     = (state_q == ST_READ) && owner_if_q && jump_mistake;
    assign mem_len   = (mem_size == 2'd0) ? 3'd1 : (mem_size == 2'd1) ? 3'd2 : 3'd4;
    assign cnt_nx    = cnt_q + 3'd1;
    // Reads lag their address by one cycle, so cnt runs to len before done.
    assign last_rd   = (cnt_q == len_q);
    assign last_wr   = (cnt_nx == len_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_d = mem_we ? ST_WRITE : ST_READ;
                end else if (grant_if) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (flush || last_rd) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (last_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        owner_if_d  = owner_if_q;
        base_d      = base_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = ram_wr_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
`ifdef IO_FULL_WAIT_EN
        io_wr_d     = io_wr_q;
        io_last_d   = 1'b0;
        io_gap_d    = io_last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_mem || grant_if) begin
                    owner_if_d = grant_if;
                    base_d     = grant_mem ? mem_addr : if_addr;
                    len_d      = grant_mem ? mem_len : 3'd4;
                    cnt_d      = 3'd0;
                    wdata_d    = mem_wdata;
                    buf_d      = 32'd0;
                    ram_a_d    = base_d;
                    ram_wr_d   = grant_mem && mem_we;
                    ram_dout_d = ram_wr_d ? mem_wdata[7:0] : 8'd0;
`ifdef IO_FULL_WAIT_EN
                    io_wr_d    = grant_mem && mem_is_io_wr;
`endif
                end
            end
            ST_READ: begin
                if (!flush) begin
                    cnt_d = cnt_nx;
                    // ram_din now holds the byte addressed in the previous cycle.
                    if (cnt_q != 3'd0) begin
                        buf_d[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = ram_din;
                    end
                    if (cnt_nx < len_q) begin
                        ram_a_d = base_q + {29'd0, cnt_nx};
                    end
                    if (last_rd) begin
                        if (owner_if_q) begin
                            if_done_d = 1'b1;
                            if_data_d = buf_d;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = buf_d;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (last_wr) begin
                    ram_wr_d   = 1'b0;
                    mem_done_d = 1'b1;
`ifdef IO_FULL_WAIT_EN
                    io_last_d  = io_wr_q;
`endif
                end else begin
                    cnt_d      = cnt_nx;
                    ram_a_d    = base_q + {29'd0, cnt_nx};
                    ram_dout_d = wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_if_q  <= 1'b0;
            base_q      <= 32'd0;
            len_q       <= 3'd0;
            cnt_q       <= 3'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            ram_a_q     <= 32'd0;
            ram_dout_q  <= 8'd0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
`ifdef IO_FULL_WAIT_EN
            io_wr_q     <= 1'b0;
            io_last_q   <= 1'b0;
            io_gap_q    <= 1'b0;
`endif
        end else if (rdy) begin
            owner_if_q  <= owner_if_d;
            base_q      <= base_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef IO_FULL_WAIT_EN
            io_wr_q     <= io_wr_d;
            io_last_q   <= io_last_d;
            io_gap_q    <= io_gap_d;
`endif
        end
    end

    // The strobe is masked directly by rdy so a frozen cycle never writes;
    // the held strobe re-issues the same byte once rdy returns.
    always_comb begin
        ram_a     = ram_a_q;
        ram_dout  = ram_dout_q;
        ram_wr    = ram_wr_q && rdy;
        if_done   = if_done_q;
        if_data   = if_data_q;
        mem_done  = mem_done_q;
        mem_rdata = mem_rdata_q;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl against a byte-array memory model
module tb_mem_ctrl;

    logic        clk, rst, rdy, jump_mistake;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        mem_req, mem_we, mem_done;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  ram_din, ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
`ifdef IO_FULL_WAIT_EN
    logic        io_buffer_full;
`endif

    mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
`ifdef IO_FULL_WAIT_EN
        .io_buffer_full(io_buffer_full),
`endif
        .jump_mistake (jump_mistake),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_done      (if_done),
        .if_data      (if_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .ram_din      (ram_din),
        .ram_a        (ram_a),
        .ram_dout     (ram_dout),
        .ram_wr       (ram_wr)
    );

    logic [7:0]  model [0:4095];
    logic [7:0]  ram   [0:4095];
    logic        sync_req;
    logic [31:0] wlog_a [$];
    logic [7:0]  wlog_d [$];
    int          passed = 0;
    int          total  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous byte RAM: data for an address appears one cycle later.
    always @(posedge clk) begin
        if (sync_req) begin
            for (int i = 0; i < 4096; i++) ram[i] <= model[i];
        end else if (ram_wr) begin
            ram[ram_a[11:0]] <= ram_dout;
        end
        ram_din <= ram[ram_a[11:0]];
    end

    always @(negedge clk) begin
        if (ram_wr) begin
            wlog_a.push_back(ram_a);
            wlog_d.push_back(ram_dout);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < n; i++) r = r | (32'(model[12'(a + 32'(i))]) << (8 * i));
        return r;
    endfunction

    task automatic model_store(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) model[12'(a + 32'(i))] = 8'(d >> (8 * i));
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_ram();
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
    endtask

    task automatic run_if(input logic [31:0] addr, input string tag);
        int          edges;
        logic        got;
        logic [31:0] expv;
        expv   = model_load(addr, 4);
        if_req = 1'b1;
        if_addr = addr;
        edges  = 0;
        got    = 1'b0;
        while (!got && edges < 40) begin
            tick();
            edges++;
            if (if_done) got = 1'b1;
        end
        if_req = 1'b0;
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, 32'(edges - 1), 32'd5);
        chk({tag, "_data"}, if_data, expv);
        tick();
    endtask

    task automatic run_mem(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input int stall, input string tag);
        int          n, edges, w0;
        logic        got;
        logic [31:0] expv;
        n    = nbytes(size);
        expv = model_load(addr, n);
        w0   = wlog_a.size();
        mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wd;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 60) begin
            if (stall > 0 && edges == 2) begin
                rdy = 1'b0;
                repeat (stall) begin
                    tick();
                    edges++;
                end
                chk({tag, "_hold_a"}, ram_a, addr + 32'd1);
                chk({tag, "_hold_wr"}, 32'(ram_wr), 32'd0);
                rdy = 1'b1;
            end
            tick();
            edges++;
            if (mem_done) got = 1'b1;
        end
        mem_req = 1'b0;
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, 32'(edges - 1), 32'((we ? n : n + 1) + stall));
        if (we) begin
            chk({tag, "_nwr"}, 32'(wlog_a.size() - w0), 32'(n));
            for (int i = 0; i < n; i++) begin
                if (w0 + i < wlog_a.size()) begin
                    chk({tag, "_wa"}, wlog_a[w0 + i], addr + 32'(i));
                    chk({tag, "_wd"}, 32'(wlog_d[w0 + i]), 32'(8'(wd >> (8 * i))));
                end
            end
            model_store(addr, n, wd);
        end else begin
            chk({tag, "_rdata"}, mem_rdata, expv);
        end
        tick();
    endtask

    initial begin
        int          edges, w0, md, id, kind;
        logic        got;
        logic [31:0] a, expv;
        logic [1:0]  sz;

        rst = 1'b0; rdy = 1'b1; jump_mistake = 1'b0; sync_req = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
`ifdef IO_FULL_WAIT_EN
        io_buffer_full = 1'b0;
`endif
        for (int i = 0; i < 4096; i++) model[i] = 8'($urandom);
        model[12'h100] = 8'h13; model[12'h101] = 8'h05;
        model[12'h102] = 8'hA0; model[12'h103] = 8'h00;
        model[12'h200] = 8'h34; model[12'h201] = 8'h12;
        sync_ram();
        tick();

        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_mem_done", 32'(mem_done), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        rst = 1'b1;
        tick();

        run_if(32'h100, "fetch100");
        chk("fetch100_const", if_data, 32'h00A00513);

        // MEM and IF requested together: MEM first, IF after MEM's dead done cycle.
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd1; mem_addr = 32'h200;
        edges = 0; md = 0; id = 0;
        while (id == 0 && edges < 60) begin
            tick();
            edges++;
            if (mem_done) begin
                md = edges;
                mem_req = 1'b0;
                chk("arb_mem_rdata", mem_rdata, 32'h0000_1234);
            end
            if (if_done) begin
                id = edges;
                if_req = 1'b0;
                chk("arb_if_data", if_data, 32'h00A00513);
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        chk("arb_mem_lat", 32'(md), 32'd4);
        chk("arb_if_edge", 32'(id), 32'(md + 7));
        tick();

        run_mem(1'b1, 2'd2, 32'h40, 32'hDEADBEEF, 0, "st40");
        run_mem(1'b0, 2'd2, 32'h40, 32'd0, 0, "ld40");
        chk("ld40_const", mem_rdata, 32'hDEADBEEF);

        // Flush a fetch two cycles in, then refetch the corrected target.
        expv = model_load(32'h80, 4);
        if_req = 1'b1; if_addr = 32'h300;
        tick();
        tick();
        jump_mistake = 1'b1; if_addr = 32'h80;
        tick();
        chk("flush_no_done", 32'(if_done), 32'd0);
        jump_mistake = 1'b0;
        edges = 0; got = 1'b0;
        while (!got && edges < 40) begin
            tick();
            edges++;
            if (if_done) got = 1'b1;
        end
        if_req = 1'b0;
        chk("flush_refetch_lat", 32'(edges), 32'd6);
        chk("flush_refetch_data", if_data, expv);
        tick();

        run_mem(1'b1, 2'd2, 32'h500, $urandom, 3, "stall_st");
        run_mem(1'b0, 2'd2, 32'h500, 32'd0, 0, "stall_ld");

        for (int i = 0; i < 20; i++) begin
            kind = int'($urandom_range(0, 2));
            a    = 32'($urandom_range(32'h800, 32'hFF0));
            sz   = 2'($urandom_range(0, 3));
            if (kind == 0) run_if(a, "rnd_if");
            else run_mem(kind == 2, sz, a, $urandom, 0, (kind == 2) ? "rnd_st" : "rnd_ld");
        end

`ifdef IO_FULL_WAIT_EN
        io_buffer_full = 1'b1;
        w0 = wlog_a.size();
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0; mem_addr = 32'h30000; mem_wdata = 32'h5A;
        got = 1'b0;
        repeat (5) begin
            tick();
            if (mem_done) got = 1'b1;
        end
        chk("io_full_no_done", 32'(got), 32'd0);
        chk("io_full_no_wr", 32'(wlog_a.size() - w0), 32'd0);
        io_buffer_full = 1'b0;
        edges = 0;
        while (!got && edges < 20) begin
            tick();
            edges++;
            if (mem_done) got = 1'b1;
        end
        mem_req = 1'b0;
        chk("io_release_edges", 32'(edges), 32'd2);
        chk("io_release_nwr", 32'(wlog_a.size() - w0), 32'd1);
        tick();
        mem_req = 1'b1; mem_wdata = 32'hC3;
        edges = 0; got = 1'b0;
        while (!got && edges < 20) begin
            tick();
            edges++;
            if (mem_done) got = 1'b1;
        end
        mem_req = 1'b0;
        chk("io_gap_edges", 32'(edges), 32'd3);
        tick();
`else
        run_mem(1'b1, 2'd0, 32'h30000, 32'h5A, 0, "io_st");
`endif

        // Asynchronous reset in the middle of a word store.
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h600; mem_wdata = 32'hA5C39611;
        tick();
        tick();
        chk("pre_rst_wr", 32'(ram_wr), 32'd1);
        chk("pre_rst_a", ram_a, 32'h601);
        #2 rst = 1'b0;
        #1;
        chk("arst_ram_a", ram_a, 32'd0);
        chk("arst_ram_dout", 32'(ram_dout), 32'd0);
        chk("arst_ram_wr", 32'(ram_wr), 32'd0);
        chk("arst_if_data", if_data, 32'd0);
        chk("arst_mem_rdata", mem_rdata, 32'd0);
        chk("arst_mem_done", 32'(mem_done), 32'd0);
        mem_req = 1'b0;
        tick();
        rst = 1'b1;
        // The abandoned store may have written its first byte; resync the RAM.
        sync_ram();
        tick();
        run_if(32'h100, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller and arbiter sharing the CPU's single byte-wide RAM port between the instruction-fetch (IF) path that consumes the PC and the MEM stage. It serializes 1/2/4-byte accesses into per-byte RAM cycles, little-endian. It grants MEM ahead of IF and aborts in-flight fetches on a branch mispredict so that the PC register's corrected target can be fetched immediately.

## Interface
- IO_ADDR, 32'h0003_0000: base of memory-mapped I/O; addresses with addr[17:16]==2'b11 are I/O.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global run enable; low = freeze.
- jump_mistake  in  1  branch mispredict flush from EX.
- if_req  in  1  fetch request; held until if_done or flush.
- if_addr  in  32  fetch address (word).
- if_done  out  1  one-cycle pulse, fetch complete.
- if_data  out  32  fetched instruction, valid with if_done.
- mem_req  in  1  data request; held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_size  in  2  0 byte, 1 half, 2 word (3 treated as word).
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data, low bytes used.
- mem_done  out  1  one-cycle pulse, access complete.
- mem_rdata  out  32  load data, zero-extended, valid with mem_done.
- ram_din  in  8  RAM read byte, one cycle after address.
- ram_a  out  32  RAM byte address.
- ram_dout  out  8  RAM write byte.
- ram_wr  out  1  RAM write strobe.

## Operation
- States: IDLE, READ, WRITE.
- IDLE grant, evaluated each enabled edge (rdy high):
  - No grant in a cycle where if_done or mem_done is high.
  - Otherwise mem_req wins over if_req.
  - if_req is not granted while jump_mistake is high.
- Grant latches owner, base address, byte count N (1/2/4; IF always 4) and write data; byte counter is cleared.
- READ: ram_a = base+k for k=0..N-1, one byte per cycle. Byte k is captured from ram_din one cycle after its address into result bits [8k+7:8k]. After byte N-1 is captured: done pulses for the owner, state returns to IDLE.
- WRITE: each cycle drive ram_a=base+k, ram_dout=wdata[8k+7:8k], ram_wr=1 for k=0..N-1. After the last byte, mem_done pulses and state returns to IDLE.
- Flush: jump_mistake high while the owner is IF returns to IDLE on that edge, with no if_done and no further RAM reads. A MEM transaction ignores jump_mistake.
- rdy low: all registers hold and ram_wr is forced 0 combinationally. On resume the current byte is re-issued; no byte is written twice with rdy high.
- Requester deassertion mid-transaction (other than IF flush) is ignored; the transaction completes.
- Reset values: state IDLE, counter 0, ram_a 0, ram_dout 0, ram_wr 0, if_done 0, mem_done 0, if_data 0, mem_rdata 0. Reset mid-transaction abandons it immediately.

## Timing
- Grant edge E0 drives the address for byte 0.
- Read done is visible after edge E0+N+1:
  - word: 5 cycles
  - half: 3 cycles
  - byte: 2 cycles
- Write done is visible after edge E0+N:
  - word: 4 cycles
  - byte: 1 cycle
  - ram_wr high for exactly N cycles.
- The done cycle is dead for arbitration, so a back-to-back grant happens on the edge after done. Minimum gap between transactions: 1 cycle.
- if_data and mem_rdata hold their last value until the next completion.

## Configuration
- IO_FULL_WAIT_EN:
  - Defined: adds input io_buffer_full (1 bit). A MEM write to an I/O address is not granted while io_buffer_full is high, nor in the cycle immediately after a previous I/O write completes (guards the buffer's 1-cycle status lag). IF may be granted meanwhile if requesting.
  - Undefined: the port is absent and I/O writes are granted like any write.

## Test plan
- Word fetch: if_req, if_addr=0x100, RAM bytes 13 05 A0 00 → if_done 5 cycles after grant, if_data=0x00A00513.
- Simultaneous if_req and mem_req: mem_req load half at 0x200 (bytes 34 12) → MEM granted first, mem_rdata=0x00001234 after 3 cycles; IF grant on the edge after mem_done.
- Store word 0xDEADBEEF at 0x40 → ram_wr high 4 cycles, ram_a 0x40..0x43, ram_dout EF BE AD DE, then mem_done.
- jump_mistake 2 cycles into an IF fetch → returns to IDLE, no if_done. A new if_req at 0x80 is granted next cycle and completes normally.
- rdy low for 3 cycles mid word-store → ram_wr 0 throughout, address held, exactly 4 bytes written, mem_done delayed 3 cycles.
- With IO_FULL_WAIT_EN, io_buffer_full=1 and a byte store to 0x30000 → no grant until io_buffer_full falls, then ram_wr for 1 cycle. Reset (rst=0) asserted mid-transaction → all outputs return to 0 asynchronously.
